// File: rtl/pc_alu_core.sv
// pc_alu_core: 4-bit PC sequencing a fixed 16-entry control ROM that selects an 8-bit ALU op on a/b.
// Optional build macro ALU_OUT_REG_EN registers alu_result/zero for one cycle of latency.
module pc_alu_core #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              pc_load,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero
);

    typedef enum logic [PC_W-1:0] {
        OP_ADD  = 'd0,
        OP_SUB  = 'd1,
        OP_AND  = 'd2,
        OP_OR   = 'd3,
        OP_XOR  = 'd4,
        OP_SLL  = 'd5,
        OP_SRL  = 'd6,
        OP_SRA  = 'd7,
        OP_SLT  = 'd8,
        OP_SLTU = 'd9
    } op_e;

    logic [PC_W-1:0]   pc_d, pc_q;
    op_e               op;
    logic [DATA_W-1:0] alu_result_d;
    logic              zero_d;

    always_comb begin
        pc_d = pc_q + 1'b1;
        if (reset) begin
            pc_d = '0;
        end else if (pc_load) begin
            pc_d = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // ROM contents are the identity map, so the opcode is the PC itself; 10..15 fall to reserved.
    always_comb begin
        op = op_e'(pc_q);
    end

    always_comb begin
        alu_result_d = '0;
        case (op)
            OP_ADD:  alu_result_d = a + b;
            OP_SUB:  alu_result_d = a - b;
            OP_AND:  alu_result_d = a & b;
            OP_OR:   alu_result_d = a | b;
            OP_XOR:  alu_result_d = a ^ b;
            OP_SLL:  alu_result_d = a << b[2:0];
            OP_SRL:  alu_result_d = a >> b[2:0];
            OP_SRA:  alu_result_d = $signed(a) >>> b[2:0];
            OP_SLT:  alu_result_d = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_result_d = {{(DATA_W-1){1'b0}}, (a < b)};
            default: alu_result_d = '0;
        endcase
        zero_d = (alu_result_d == '0);
    end

`ifdef ALU_OUT_REG_EN
    logic [DATA_W-1:0] alu_result_q;
    logic              zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result_q <= '0;
            zero_q       <= 1'b1;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
        end
    end

    assign alu_result = alu_result_q;
    assign zero       = zero_q;
`else
    assign alu_result = alu_result_d;
    assign zero       = zero_d;
`endif

endmodule

// File: tb/tb_pc_alu_core.sv
// Directed/scoreboarded bench for pc_alu_core; honours ALU_OUT_REG_EN when defined for the build.
module tb_pc_alu_core;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] pc_in;
    logic       pc_load;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] alu_result;
    logic       zero;

    int   checks = 0;
    int   errors = 0;
    logic [3:0] pc_m = '0;
    exp_t q[$];

    pc_alu_core #(.DATA_W(8), .PC_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_load    (pc_load),
        .a          (a),
        .b          (b),
        .alu_result (alu_result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        int unsigned sh;
        sh = int'(y[2:0]);
        r  = x;
        case (op)
            4'd0: r = x + y;
            4'd1: r = x + ~y + 8'd1;
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: for (int unsigned i = 0; i < sh; i++) r = {r[6:0], 1'b0};
            4'd6: for (int unsigned i = 0; i < sh; i++) r = {1'b0, r[7:1]};
            4'd7: for (int unsigned i = 0; i < sh; i++) r = {r[7], r[7:1]};
            4'd8: r = ((x ^ 8'h80) < (y ^ 8'h80)) ? 8'd1 : 8'd0;
            4'd9: r = (x < y) ? 8'd1 : 8'd0;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic compare_front(input string tag);
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        checks++;
        assert (alu_result === e.res) else begin
            errors++;
            $error("FAIL %s alu_result: got %02h expected %02h", tag, alu_result, e.res);
        end
        checks++;
        assert (zero === e.z) else begin
            errors++;
            $error("FAIL %s zero: got %0b expected %0b", tag, zero, e.z);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic ld,
                        input logic [3:0] pin, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        reset   = rst;
        pc_load = ld;
        pc_in   = pin;
        a       = av;
        b       = bv;
        e.res   = ref_alu(pc_m, av, bv);
        e.z     = (e.res == 8'h00);
`ifdef ALU_OUT_REG_EN
        if (rst) begin
            e.res = 8'h00;
            e.z   = 1'b1;
        end
        @(negedge clk);
        compare_front(tag);
        q.push_back(e);
`else
        q.push_back(e);
        @(negedge clk);
        compare_front(tag);
`endif
        @(posedge clk);
        if (rst)     pc_m = '0;
        else if (ld) pc_m = pin;
        else         pc_m = pc_m + 4'd1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        pc_load = 1'b0;
        pc_in   = '0;
        a       = 8'h0A;
        b       = 8'h02;
        @(posedge clk);
        #1;
        pc_m = '0;
`ifdef ALU_OUT_REG_EN
        q.push_back(exp_t'{res: 8'h00, z: 1'b1});
`endif
        step("reset_add",  1'b0, 1'b0, 4'd0,  8'h0A, 8'h02);
        step("sub",        1'b0, 1'b0, 4'd0,  8'h0A, 8'h02);
        step("and_ld4",    1'b0, 1'b1, 4'd4,  8'h0A, 8'h02);
        step("xor",        1'b0, 1'b0, 4'd0,  8'h0B, 8'h03);
        step("sll",        1'b0, 1'b0, 4'd0,  8'h0B, 8'h03);
        step("srl",        1'b0, 1'b0, 4'd0,  8'h0B, 8'h03);
        step("sra_ld8",    1'b0, 1'b1, 4'd8,  8'h0B, 8'h03);
        step("slt_neg",    1'b0, 1'b0, 4'd0,  8'hF2, 8'hD3);
        step("sltu_ld9",   1'b0, 1'b1, 4'd9,  8'hF2, 8'hD3);
        step("sltu_swap",  1'b0, 1'b0, 4'd0,  8'hD3, 8'hF2);
        step("rsv10_ld15", 1'b0, 1'b1, 4'd15, 8'hFF, 8'hFF);
        step("rsv15",      1'b0, 1'b0, 4'd0,  8'hFF, 8'hFF);
        step("wrap_add",   1'b0, 1'b0, 4'd0,  8'hFF, 8'h01);
        step("sub_neg",    1'b0, 1'b0, 4'd0,  8'h05, 8'h07);
        step("and",        1'b0, 1'b0, 4'd0,  8'hC3, 8'h5A);
        step("or",         1'b0, 1'b0, 4'd0,  8'hC3, 8'h5A);
        step("rst_ld7",    1'b1, 1'b1, 4'd7,  8'h12, 8'h34);
        step("add_ld7",    1'b0, 1'b1, 4'd7,  8'h55, 8'h55);
        step("sra_neg",    1'b0, 1'b0, 4'd0,  8'h80, 8'h01);
        step("slt_min",    1'b0, 1'b0, 4'd0,  8'h80, 8'h01);
        step("sltu_min",   1'b0, 1'b0, 4'd0,  8'h80, 8'h01);
        step("sll_ld5",    1'b0, 1'b1, 4'd5,  8'h00, 8'h00);
        step("sll_max",    1'b0, 1'b0, 4'd0,  8'hFF, 8'hFF);
        step("srl_max",    1'b0, 1'b0, 4'd0,  8'hFF, 8'hFF);
        step("sra_max",    1'b0, 1'b0, 4'd0,  8'h81, 8'h0F);
        for (int k = 0; k < 20; k++) begin
            step("rand", 1'b0, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
`ifdef ALU_OUT_REG_EN
        @(negedge clk);
        compare_front("drain");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
